// File: rtl/mac_array_drain.sv
// Result drain for the 2x2 MAC array: per-lane capture, clear pulse, round-robin serialiser.
// Optional DRAIN_RELU_EN zeroes negative results at output load.
module mac_array_drain #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  output logic [N_MACS-1:0]       clear_out,
  output logic signed [ACC_W-1:0] out_data,
  output logic [1:0]              out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [N_MACS-1:0]       overrun,
  input  logic                    ovr_clr
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_slot [N_MACS];
  logic [N_MACS-1:0]       r_pend;
  logic [N_MACS-1:0]       r_clear;
  logic [N_MACS-1:0]       r_ovr;
  logic [1:0]              r_ptr;
  logic [1:0]              r_idx;
  logic signed [ACC_W-1:0] r_data;
  logic                    r_valid;

  logic signed [ACC_W-1:0] w_acc [N_MACS];
  logic                    w_hs;
  logic [N_MACS-1:0]       w_free;
  logic [N_MACS-1:0]       w_cap;
  logic [N_MACS-1:0]       w_ovr_ev;
  logic [2:0]              w_pick_i;
  logic [2:0]              w_pick_e;

  // {found, index} of first set bit scanning s, s+1, ... mod 4
  function automatic logic [2:0] f_pick(
    input logic [N_MACS-1:0] m,
    input logic [1:0]        s
  );
    logic [1:0] j;
    logic [2:0] res;
    res = '0;
    for (int k = 0; k < N_MACS; k++) begin
      j = s + 2'(k);
      if (!res[2] && m[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  function automatic logic signed [ACC_W-1:0] f_out(
    input logic signed [ACC_W-1:0] v
  );
`ifdef DRAIN_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign w_acc[0] = acc_in_0;
  assign w_acc[1] = acc_in_1;
  assign w_acc[2] = acc_in_2;
  assign w_acc[3] = acc_in_3;

  assign w_hs     = r_valid & out_ready;
  assign w_free   = w_hs ? (N_MACS'(1) << r_idx) : '0;
  assign w_cap    = valid_in & (~r_pend | w_free);
  assign w_ovr_ev = valid_in & r_pend & ~w_free;
  assign w_pick_i = f_pick(r_pend, r_ptr);
  assign w_pick_e = f_pick(r_pend & ~w_free, r_idx + 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MACS; i++) r_slot[i] <= '0;
      r_pend  <= '0;
      r_clear <= '0;
      r_ovr   <= '0;
    end else begin
      for (int i = 0; i < N_MACS; i++)
        if (w_cap[i]) r_slot[i] <= w_acc[i];
      r_pend  <= (r_pend & ~w_free) | w_cap;
      r_clear <= w_cap;
      // A fresh drop in the clear cycle keeps its bit set
      r_ovr   <= (ovr_clr ? '0 : r_ovr) | w_ovr_ev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_i[2]) begin
            r_idx   <= w_pick_i[1:0];
            r_data  <= f_out(r_slot[w_pick_i[1:0]]);
            r_valid <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            r_ptr <= r_idx + 2'd1;
            if (w_pick_e[2]) begin
              r_idx  <= w_pick_e[1:0];
              r_data <= f_out(r_slot[w_pick_e[1:0]]);
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign clear_out = r_clear;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign overrun   = r_ovr;
  assign busy      = (|r_pend) | r_valid;

endmodule

// File: tb/tb_mac_array_drain.sv
// Directed self-checking bench for mac_array_drain.
// Expected RELU results follow DRAIN_RELU_EN when defined.
module tb_mac_array_drain;

  localparam int ACC_W = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [ACC_W-1:0] acc_in_0 = '0;
  logic signed [ACC_W-1:0] acc_in_1 = '0;
  logic signed [ACC_W-1:0] acc_in_2 = '0;
  logic signed [ACC_W-1:0] acc_in_3 = '0;
  logic [3:0]              valid_in = '0;
  logic [3:0]              clear_out;
  logic signed [ACC_W-1:0] out_data;
  logic [1:0]              out_idx;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    busy;
  logic [3:0]              overrun;
  logic                    ovr_clr = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  mac_array_drain #(.ACC_W(ACC_W), .N_MACS(4)) dut (
    .clk(clk), .rst(rst),
    .acc_in_0(acc_in_0), .acc_in_1(acc_in_1),
    .acc_in_2(acc_in_2), .acc_in_3(acc_in_3),
    .valid_in(valid_in), .clear_out(clear_out),
    .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(string nm, logic [1:0] ei, logic signed [ACC_W-1:0] ed);
    n_tot++;
    if (out_valid !== 1'b1 || out_idx !== ei || out_data !== ed)
      $display("FAIL %s: got v=%b idx=%0d data=%0d, exp v=1 idx=%0d data=%0d",
               nm, out_valid, out_idx, out_data, ei, ed);
    else n_pass++;
  endtask

  task automatic chk4(string nm, logic [3:0] got, logic [3:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %b exp %b", nm, got, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk4("reset_outs", {clear_out[0], out_valid, busy, |overrun},
         4'b0000);
    n_tot++;
    if (out_data !== '0 || out_idx !== 2'd0)
      $display("FAIL reset_data: got %0d/%0d exp 0/0", out_data, out_idx);
    else n_pass++;
    valid_in = 4'b0001; acc_in_0 = 16'sd25;
    tick();
    valid_in = '0;
    chk4("rst_clear", clear_out, 4'b0001);
    chk4("rst_noval", {3'b0, out_valid}, 4'b0000);
    tick();
    chk_word("rst_first", 2'd0, 16'sd25);
    chk4("rst_clr_done", clear_out, 4'b0000);
    #2 rst = 1'b1;
    #1;
    chk4("async_rst", {clear_out[0], out_valid, busy, |overrun}, 4'b0000);
    n_tot++;
    if (out_data !== '0) $display("FAIL async_rst_data: got %0d exp 0", out_data);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    chk4("rst_discard", {2'b0, out_valid, busy}, 4'b0000);
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b1;
    valid_in = 4'b1111;
    acc_in_0 = 16'sd1; acc_in_1 = 16'sd2;
    acc_in_2 = 16'sd3; acc_in_3 = 16'sd4;
    tick();
    valid_in = '0;
    chk4("sim_clear", clear_out, 4'b1111);
    tick();
    chk4("sim_clear_pulse", clear_out, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk_word("sim_word", 2'(k), 16'(k + 1));
      n_tot++;
      if (busy !== 1'b1) $display("FAIL sim_busy: got %b exp 1", busy);
      else n_pass++;
      tick();
    end
    chk4("sim_done", {2'b0, out_valid, busy}, 4'b0000);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    valid_in = 4'b0100; acc_in_2 = -16'sd7;
    tick();
    valid_in = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_word("bp_stable", 2'd2, -16'sd7);
      tick();
    end
    chk_word("bp_hold_last", 2'd2, -16'sd7);
    out_ready = 1'b1;
    tick();
    chk4("bp_hs", {2'b0, out_valid, busy}, 4'b0000);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    valid_in = 4'b0010; acc_in_1 = 16'sd11;
    tick();
    valid_in = '0;
    tick();
    chk_word("ovr_first", 2'd1, 16'sd11);
    valid_in = 4'b0010; acc_in_1 = 16'sd99;
    tick();
    valid_in = '0;
    chk4("ovr_flag", overrun, 4'b0010);
    chk4("ovr_noclear", clear_out, 4'b0000);
    chk_word("ovr_kept", 2'd1, 16'sd11);
    out_ready = 1'b1;
    tick();
    chk4("ovr_drained", {2'b0, out_valid, busy}, 4'b0000);
    chk4("ovr_sticky", overrun, 4'b0010);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk4("ovr_clr", overrun, 4'b0000);
  endtask

  task automatic test_round_robin();
    out_ready = 1'b1;
    valid_in = 4'b1000; acc_in_3 = 16'sd33;
    tick();
    valid_in = '0;
    tick();
    chk_word("rr_lane3", 2'd3, 16'sd33);
    tick();
    valid_in = 4'b1001; acc_in_0 = 16'sd5; acc_in_3 = 16'sd6;
    tick();
    valid_in = '0;
    chk4("rr_clear", clear_out, 4'b1001);
    tick();
    chk_word("rr_first0", 2'd0, 16'sd5);
    tick();
    chk_word("rr_then3", 2'd3, 16'sd6);
    tick();
    chk4("rr_done", {2'b0, out_valid, busy}, 4'b0000);
  endtask

  task automatic test_relu();
    logic signed [ACC_W-1:0] e0;
`ifdef DRAIN_RELU_EN
    e0 = '0;
`else
    e0 = -16'sd100;
`endif
    out_ready = 1'b1;
    valid_in = 4'b0011; acc_in_0 = -16'sd100; acc_in_1 = 16'sd50;
    tick();
    valid_in = '0;
    tick();
    chk_word("relu_neg", 2'd0, e0);
    tick();
    chk_word("relu_pos", 2'd1, 16'sd50);
    tick();
    chk4("relu_done", {2'b0, out_valid, busy}, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_backpressure();
    test_overrun();
    test_round_robin();
    test_relu();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mac_array_drain.md
Name: mac_array_drain

Overview:
- Result-side consumer for the 2x2 MAC array.
- Captures per-MAC accumulator results when each MAC's valid_out fires, then issues the matching per-MAC clear pulse back to the array.
- Serialises captured results onto a single valid/ready output stream tagged with the MAC index, for the writeback/output buffer.

Parameters:
- ACC_W, 16, accumulator/result width (matches array ACC_W)
- N_MACS, 4, number of MAC lanes; fixed at 4 (index width 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- acc_in_0  input  ACC_W  signed result from MAC 0
- acc_in_1  input  ACC_W  signed result from MAC 1
- acc_in_2  input  ACC_W  signed result from MAC 2
- acc_in_3  input  ACC_W  signed result from MAC 3
- valid_in  input  N_MACS  per-lane result-valid (array valid_out)
- clear_out  output  N_MACS  per-lane clear pulse to array clear
- out_data  output  ACC_W  signed serialised result
- out_idx  output  2  MAC index of out_data
- out_valid  output  1  out_data/out_idx valid
- out_ready  input  1  downstream accepts when high with out_valid
- busy  output  1  any lane pending or out_valid high
- overrun  output  N_MACS  sticky per-lane drop flag
- ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst=1): clear_out=0, out_data=0, out_idx=0, out_valid=0, busy=0, overrun=0.
- Reset also clears all slot registers, pending bits and the round-robin pointer ptr (resets to 0) immediately.
- Reset mid-transfer discards held data. out_valid drops asynchronously.
- Per-lane slot: one ACC_W register plus a pending bit.
- Capture:
  - If valid_in[i]=1 and slot i is free (or freed this same cycle by a handshake on lane i), latch acc_in_i and set pending[i].
  - clear_out[i] is a registered one-cycle pulse in the cycle after capture.
- Overrun:
  - If valid_in[i]=1 while slot i is pending and not freed this cycle, drop the new value and set overrun[i].
  - No clear_out[i] is issued for a dropped value.
- valid_in held high on a free slot captures each cycle it is high. Each capture produces its own clear pulse.
- FSM states: IDLE and EMIT.
  - IDLE: if any pending, select the first pending lane scanning ptr, ptr+1, ... (mod 4). Load out_data/out_idx from it, set out_valid, go to EMIT.
  - EMIT: out_data/out_idx/out_valid stay stable until out_ready=1.
  - On handshake: clear pending[sel] and set ptr=sel+1 mod 4.
  - If another lane is pending, excluding sel, load it in the same edge and stay in EMIT (back-to-back, no bubble). Otherwise go to IDLE with out_valid=0.
- Latency: valid_in at cycle t gives pending at edge t+1 and out_valid at edge t+2 (minimum 2 cycles). Sustained throughput is 1 word/cycle.
- Simultaneous valid_in on several lanes: all are captured in the same cycle, all matching clear_out bits pulse together, and they emit in round-robin order.
- busy = OR(pending) | out_valid (registered-equivalent, no combinational path from inputs).
- ovr_clr=1 zeroes overrun at the next edge. A new overrun event in that same cycle wins (bit set).
- Arithmetic: data is passed through unchanged, signed ACC_W, no width change.

Optional Feature:
- Macro DRAIN_RELU_EN.
- Defined: out_data = 0 when the selected slot value is negative (MSB=1), otherwise the value. Applied at output load, so the slot keeps its raw value.
- Not defined: out_data is the raw captured value. No extra logic.

Test Plan:
- Reset check: assert rst async mid-cycle -> all outputs 0 immediately. Release, valid_in=0001, acc_in_0=16'sd25 -> clear_out=0001 one cycle later. out_valid=1, out_idx=0, out_data=25 two edges after valid_in.
- Simultaneous capture: valid_in=1111 with values 1,2,3,4, out_ready=1 -> clear_out=1111 for one cycle. Outputs idx 0,1,2,3 data 1,2,3,4 on four consecutive cycles. busy falls after the last word.
- Backpressure: out_ready=0 for 5 cycles with lane 2 holding -7 -> out_data=-7, out_idx=2 stable. Handshake happens on the first cycle out_ready=1.
- Overrun: lane 1 pending and stalled, second valid_in[1] with value 99 -> overrun=0010, no clear pulse, first value still emitted. ovr_clr -> overrun=0000.
- Round-robin: emit lane 3, then capture lanes 0 and 3 together -> order is 0 then 3.
- RELU (DRAIN_RELU_EN defined): acc_in_0=-100, acc_in_1=50 -> out_data 0 then 50. Without the macro -> -100 then 50.
